interrupt_unit: RTL and testbench

Interrupt unit for the MSP430 CPU: converts the system reset pin, the NMI pin and the maskable interrupt lines into the registered `rstReq` and `INTREQ` controls consumed by CAR latch control. It also supplies the vector-table address that the interrupt microsequence reads. The block commits one request at a time and completes it with an `INTACK` pulse from the control unit. That pulse returns a one-hot clear to the accepted maskable source.

---
 rtl/interrupt_unit_if.sv | 24 ++
 rtl/interrupt_unit.sv | 131 +++++++++++++
 tb/tb_interrupt_unit.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/interrupt_unit_if.sv
// Interrupt-unit bus: request pins and CPU handshake in, CAR-latch controls out.
// The unit itself connects through the slave modport.
interface interrupt_unit_if #(
  parameter int N_IRQ = 8
);
  logic             NMI;
  logic             GIE;
  logic [N_IRQ-1:0] IRQ;
  logic             INTACK;
  logic             rstReq;
  logic             INTREQ;
  logic [15:0]      IntAddr;
  logic [N_IRQ-1:0] IRQ_clr;

  modport master (
    output NMI, GIE, IRQ, INTACK,
    input  rstReq, INTREQ, IntAddr, IRQ_clr
  );

  modport slave (
    input  NMI, GIE, IRQ, INTACK,
    output rstReq, INTREQ, IntAddr, IRQ_clr
  );
endinterface

// File: rtl/interrupt_unit.sv
// MSP430 interrupt unit: reset hold, NMI edge latch, priority select and
// single committed request with INTACK completion and one-hot source clear.
module interrupt_unit #(
  parameter int N_IRQ    = 8,
  parameter int RST_HOLD = 2
) (
  input  logic             clk,
  input  logic             rst,
  interrupt_unit_if.slave  bus
);
  localparam int              IDW      = $clog2(N_IRQ + 1);
  localparam logic [IDW-1:0]  ID_NMI   = IDW'(N_IRQ);
  localparam logic [15:0]     VEC_RST  = 16'hFFFE;
  localparam logic [15:0]     VEC_NMI  = 16'hFFFC;
  localparam logic [15:0]     VEC_IRQ0 = 16'hFFFA;

  typedef enum logic [1:0] {S_RESET, S_IDLE, S_REQ} state_t;

  state_t           state_reg, state_next;
  logic [3:0]       cnt_reg, cnt_next;
  logic             nmi_prev_reg;
  logic             nmi_pend_reg, nmi_pend_next;
  logic             rstreq_reg, rstreq_next;
  logic             intreq_reg, intreq_next;
  logic [15:0]      intaddr_reg, intaddr_next;
  logic [IDW-1:0]   id_reg, id_next;
  logic [N_IRQ-1:0] clr_reg, clr_next;
  logic [N_IRQ-1:0] id_onehot;

  logic             sel_valid;
  logic [IDW-1:0]   sel_id;
  logic [15:0]      sel_vec;
  logic             nmi_edge;

  assign nmi_edge = bus.NMI & ~nmi_prev_reg;

  // Pending NMI beats everything; otherwise the lowest enabled IRQ index wins.
  always_comb begin
    sel_valid = nmi_pend_reg;
    sel_id    = ID_NMI;
    sel_vec   = VEC_NMI;
    if (!nmi_pend_reg) begin
      for (int i = N_IRQ - 1; i >= 0; i--) begin
        if (bus.IRQ[i] && bus.GIE) begin
          sel_valid = 1'b1;
          sel_id    = IDW'(i);
          sel_vec   = VEC_IRQ0 - 16'(2 * i);
        end
      end
    end
  end

  // Ids outside 0..N_IRQ-1 (NMI or unused codes) decode to no clear at all.
  generate
    for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_clr
      assign id_onehot[gi] = (id_reg == IDW'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_RESET;
      cnt_reg      <= 4'(RST_HOLD);
      nmi_prev_reg <= bus.NMI;
      nmi_pend_reg <= 1'b0;
      rstreq_reg   <= 1'b1;
      intreq_reg   <= 1'b0;
      intaddr_reg  <= VEC_RST;
      id_reg       <= ID_NMI;
      clr_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      nmi_prev_reg <= bus.NMI;
      nmi_pend_reg <= nmi_pend_next;
      rstreq_reg   <= rstreq_next;
      intreq_reg   <= intreq_next;
      intaddr_reg  <= intaddr_next;
      id_reg       <= id_next;
      clr_reg      <= clr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_RESET: if (cnt_reg == 4'd0) state_next = S_IDLE;
      S_IDLE:  if (sel_valid) state_next = S_REQ;
      S_REQ:   if (bus.INTACK) state_next = S_IDLE;
      default: state_next = S_RESET;
    endcase
  end

  always_comb begin
    cnt_next      = cnt_reg;
    nmi_pend_next = nmi_pend_reg;
    intaddr_next  = intaddr_reg;
    id_next       = id_reg;
    clr_next      = '0;
    case (state_reg)
      S_RESET: begin
        if (cnt_reg != 4'd0) cnt_next = cnt_reg - 4'd1;
      end
      S_IDLE: begin
        if (sel_valid) begin
          intaddr_next = sel_vec;
          id_next      = sel_id;
        end
      end
      S_REQ: begin
        if (bus.INTACK) begin
          if (id_reg == ID_NMI) nmi_pend_next = 1'b0;
          else                  clr_next      = id_onehot;
        end else if (nmi_pend_reg && id_reg != ID_NMI) begin
          intaddr_next = VEC_NMI;
          id_next      = ID_NMI;
        end
      end
      default: ;
    endcase
    // A fresh edge outranks an acknowledge clear landing in the same cycle.
    if (state_reg != S_RESET && nmi_edge) nmi_pend_next = 1'b1;
    rstreq_next = (state_next == S_RESET);
    intreq_next = (state_next == S_REQ);
  end

  assign bus.rstReq  = rstreq_reg;
  assign bus.INTREQ  = intreq_reg;
  assign bus.IntAddr = intaddr_reg;
  assign bus.IRQ_clr = clr_reg;
endmodule

// File: tb/tb_interrupt_unit.sv
// Self-checking bench for interrupt_unit: directed scenarios then random traffic,
// every cycle compared against a behavioural model of the interrupt rules.
module tb_interrupt_unit;
  localparam int N_IRQ    = 8;
  localparam int RST_HOLD = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  interrupt_unit_if #(.N_IRQ(N_IRQ)) bus ();

  interrupt_unit #(.N_IRQ(N_IRQ), .RST_HOLD(RST_HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: cycles since reset release, committed request, NMI latch.
  int               m_since = 0;
  bit               m_busy  = 1'b0;
  int               m_src   = -1;     // -1 denotes the NMI
  logic [15:0]      m_vec   = 16'hFFFE;
  bit               m_pend  = 1'b0;
  bit               m_prev  = 1'b0;
  logic [N_IRQ-1:0] m_clr   = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    bit in_rst;
    bit edge_nmi;
    int s;
    @(posedge clk);
    if (rst) begin
      m_since = 0;
      m_busy  = 1'b0;
      m_vec   = 16'hFFFE;
      m_pend  = 1'b0;
      m_clr   = '0;
      m_src   = -1;
    end else begin
      in_rst   = (m_since <= RST_HOLD);
      edge_nmi = bus.NMI && !m_prev;
      m_clr    = '0;
      if (m_since <= RST_HOLD) m_since++;
      if (!in_rst) begin
        if (m_busy) begin
          if (bus.INTACK) begin
            m_busy = 1'b0;
            if (m_src < 0) m_pend = 1'b0;
            else           m_clr[m_src] = 1'b1;
            $display("ack vec=%h src=%0d clr=%b", m_vec, m_src, m_clr);
          end else if (m_pend && m_src >= 0) begin
            m_src = -1;
            m_vec = 16'hFFFC;
          end
        end else begin
          s = -2;
          if (m_pend) s = -1;
          else if (bus.GIE)
            for (int i = N_IRQ - 1; i >= 0; i--) if (bus.IRQ[i]) s = i;
          if (s != -2) begin
            m_busy = 1'b1;
            m_src  = s;
            m_vec  = (s < 0) ? 16'hFFFC : 16'(32'hFFFA - 2 * s);
          end
        end
        if (edge_nmi) m_pend = 1'b1;
      end
    end
    m_prev = bus.NMI;
    #1;
    check("rstReq",  bus.rstReq,  32'(m_since <= RST_HOLD));
    check("INTREQ",  bus.INTREQ,  32'(m_busy));
    check("IntAddr", bus.IntAddr, m_vec);
    check("IRQ_clr", bus.IRQ_clr, m_clr);
  endtask

  initial begin
    rst = 1'b1;
    bus.NMI = 1'b0; bus.GIE = 1'b0; bus.IRQ = '0; bus.INTACK = 1'b0;

    // Reset: three cycles high, rstReq must hold for RST_HOLD cycles after release
    repeat (3) step();
    check("rst_rstReq", bus.rstReq, 1);
    check("rst_addr", bus.IntAddr, 16'hFFFE);
    check("rst_intreq", bus.INTREQ, 0);
    rst = 1'b0;
    step(); check("rel1_rstReq", bus.rstReq, 1);
    step(); check("rel2_rstReq", bus.rstReq, 1);
    step(); check("rel3_rstReq", bus.rstReq, 0);
    check("rel3_addr", bus.IntAddr, 16'hFFFE);

    // Maskable priority
    bus.GIE = 1'b1; bus.IRQ = 8'b0010_0100;
    step(); check("prio_req", bus.INTREQ, 1); check("prio_addr2", bus.IntAddr, 16'hFFF6);
    bus.INTACK = 1'b1;
    step(); check("prio_clr2", bus.IRQ_clr, 8'h04); check("prio_drop", bus.INTREQ, 0);
    bus.INTACK = 1'b0; bus.IRQ = 8'b0010_0000;
    step(); check("prio_addr5", bus.IntAddr, 16'hFFF0); check("prio_clr_off", bus.IRQ_clr, 0);
    bus.INTACK = 1'b1;
    step(); check("prio_clr5", bus.IRQ_clr, 8'h20);
    bus.INTACK = 1'b0; bus.IRQ = '0;
    step(); check("prio_idle", bus.INTREQ, 0);

    // Masking and NMI
    bus.GIE = 1'b0; bus.IRQ = 8'hFF;
    step(); step(); check("mask_intreq", bus.INTREQ, 0);
    bus.NMI = 1'b1;
    step(); check("nmi_lat", bus.INTREQ, 0);
    step(); check("nmi_req", bus.INTREQ, 1); check("nmi_addr", bus.IntAddr, 16'hFFFC);
    bus.INTACK = 1'b1;
    step(); check("nmi_clr", bus.IRQ_clr, 0); check("nmi_drop", bus.INTREQ, 0);
    bus.INTACK = 1'b0;
    step(); check("nmi_done", bus.INTREQ, 0);
    bus.NMI = 1'b0; bus.IRQ = '0; bus.GIE = 1'b1;

    // NMI upgrade of a committed maskable request
    bus.IRQ = 8'h01;
    step(); check("upg_addr0", bus.IntAddr, 16'hFFFA);
    bus.IRQ = '0; bus.NMI = 1'b1;
    step(); check("upg_hold", bus.IntAddr, 16'hFFFA);
    step(); check("upg_addr", bus.IntAddr, 16'hFFFC); check("upg_req", bus.INTREQ, 1);
    bus.INTACK = 1'b1;
    step(); check("upg_clr", bus.IRQ_clr, 0);
    bus.INTACK = 1'b0;
    step(); check("upg_idle", bus.INTREQ, 0);
    bus.NMI = 1'b0;
    step();

    // NMI edge coinciding with the acknowledge of an NMI
    bus.NMI = 1'b1;
    step();
    step(); check("sim_req", bus.INTREQ, 1);
    bus.NMI = 1'b0;
    step();
    bus.NMI = 1'b1; bus.INTACK = 1'b1;
    step(); check("sim_gap", bus.INTREQ, 0);
    bus.INTACK = 1'b0;
    step(); check("sim_rereq", bus.INTREQ, 1); check("sim_addr", bus.IntAddr, 16'hFFFC);
    bus.INTACK = 1'b1;
    step();
    bus.INTACK = 1'b0;
    step(); check("sim_quiet", bus.INTREQ, 0);

    // Reset in the middle of a request, NMI held high across it
    bus.NMI = 1'b0;
    step();
    bus.IRQ = 8'h08;
    step(); check("mid_addr", bus.IntAddr, 16'hFFF4);
    rst = 1'b1; bus.NMI = 1'b1;
    step();
    check("mid_intreq", bus.INTREQ, 0); check("mid_rstReq", bus.rstReq, 1);
    check("mid_clr", bus.IRQ_clr, 0);
    rst = 1'b0; bus.IRQ = '0;
    repeat (5) step();
    check("mid_noreq", bus.INTREQ, 0); check("mid_rel", bus.rstReq, 0);

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 15) == 0) bus.NMI = ~bus.NMI;
      if ($urandom_range(0, 7) == 0) bus.GIE = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) bus.IRQ = N_IRQ'($urandom) & N_IRQ'($urandom);
      bus.INTACK = (m_busy || m_since <= RST_HOLD) && ($urandom_range(0, 2) == 0);
      step();
      bus.IRQ = bus.IRQ & ~m_clr;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
